// File: rtl/counter_pkg.sv
// Shared FSM state encoding and run_dir status codes for the auto up/down counter.
package counter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM_UP = 3'd1,
        RUN_UP = 3'd2,
        ARM_DN = 3'd3,
        RUN_DN = 3'd4
    } state_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    // Status code shown on run_dir for a given state; armed states report idle.
    function automatic logic [1:0] dir_of(state_t s);
        case (s)
            RUN_UP:  return DIR_UP;
            RUN_DN:  return DIR_DN;
            default: return DIR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/auto_updown_counter_if.sv
// Button/load inputs and registered count/status outputs of the auto up/down counter.
interface auto_updown_counter_if #(
    parameter int WIDTH = 7
);
    logic             up;
    logic             down;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [1:0]       run_dir;
    logic             wrap;

    // Driver side (buttons, load), e.g. a controller or testbench.
    modport master (
        output up, down, stop, load, load_val,
        input  count, run_dir, wrap
    );

    // Counter side.
    modport slave (
        input  up, down, stop, load, load_val,
        output count, run_dir, wrap
    );
endinterface

// File: rtl/tick_gen.sv
// Prescaler: tick is high on every DIV-th cycle after the last clear.
module tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 1) begin : g_div_chk
        $error("tick_gen: DIV must be >= 1");
    end

    logic [CW-1:0] cnt;

    // Phase counter: restart on clear, otherwise roll over at DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   cnt <= '0;
        else if (clr || cnt == LAST) cnt <= '0;
        else                         cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/auto_updown_counter.sv
// Push-and-release auto up/down counter: a press arms a direction, release starts
// stepping every DIV clocks, with wrap or saturation at 0..MAX.
module auto_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int MAX      = 100,
    parameter int DIV      = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    auto_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    if (MAX < 1 || MAX >= (1 << WIDTH)) begin : g_max_chk
        $error("auto_updown_counter: MAX must satisfy 1 <= MAX < 2**WIDTH");
    end
    if (DIV < 1) begin : g_div_chk
        $error("auto_updown_counter: DIV must be >= 1");
    end

    state_t           state, state_nxt;
    logic             tick, clr;
    logic             release_edge, run_stay, step;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic [1:0]       dir_nxt;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: load > stop > up > down; up always (re)arms upward.
    always_comb begin
        state_nxt = state;
        if (bus.load || bus.stop) begin
            state_nxt = IDLE;
        end else if (bus.up) begin
            state_nxt = ARM_UP;
        end else begin
            case (state)
                ARM_UP:               state_nxt = RUN_UP;
                ARM_DN:               state_nxt = bus.down ? ARM_DN : RUN_DN;
                IDLE, RUN_UP, RUN_DN: state_nxt = bus.down ? ARM_DN : state;
                default:              state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: one step on release, then one per prescaler tick while running.
    always_comb begin
        release_edge = (state == ARM_UP && state_nxt == RUN_UP) ||
                       (state == ARM_DN && state_nxt == RUN_DN);
        run_stay     = (state == RUN_UP || state == RUN_DN) && (state_nxt == state);
        clr          = !run_stay;
        step         = release_edge || (run_stay && tick);
        dir_nxt      = dir_of(state_nxt);
        count_nxt    = bus.count;
        wrap_nxt     = 1'b0;
        if (bus.load) begin
            count_nxt = (bus.load_val > MAXV) ? MAXV : bus.load_val;
        end else if (step) begin
            if (state_nxt == RUN_UP) begin
                if (bus.count == MAXV) begin
                    wrap_nxt  = 1'b1;
                    count_nxt = SATURATE ? MAXV : '0;
                end else begin
                    count_nxt = bus.count + WIDTH'(1);
                end
            end else begin
                if (bus.count == '0) begin
                    wrap_nxt  = 1'b1;
                    count_nxt = SATURATE ? '0 : MAXV;
                end else begin
                    count_nxt = bus.count - WIDTH'(1);
                end
            end
        end
    end

    // Registered outputs, updated together with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.count   <= '0;
            bus.run_dir <= DIR_IDLE;
            bus.wrap    <= 1'b0;
        end else begin
            bus.count   <= count_nxt;
            bus.run_dir <= dir_nxt;
            bus.wrap    <= wrap_nxt;
        end
    end
endmodule

// File: tb/tb_auto_updown_counter.sv
// Drives three counter configurations (wrap/DIV=1, saturate/DIV=1, wrap/DIV=3) with
// the same directed and random stimulus and compares them to a behavioural model.
module tb_auto_updown_counter;
    localparam int W    = 7;
    localparam int MAXC = 100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic         i_up = 1'b0, i_dn = 1'b0, i_stop = 1'b0, i_load = 1'b0;
    logic [W-1:0] i_lv = '0;

    auto_updown_counter_if #(.WIDTH(W)) if0 ();
    auto_updown_counter_if #(.WIDTH(W)) if1 ();
    auto_updown_counter_if #(.WIDTH(W)) if2 ();

    assign if0.up = i_up; assign if0.down = i_dn; assign if0.stop = i_stop;
    assign if0.load = i_load; assign if0.load_val = i_lv;
    assign if1.up = i_up; assign if1.down = i_dn; assign if1.stop = i_stop;
    assign if1.load = i_load; assign if1.load_val = i_lv;
    assign if2.up = i_up; assign if2.down = i_dn; assign if2.stop = i_stop;
    assign if2.load = i_load; assign if2.load_val = i_lv;

    auto_updown_counter #(.WIDTH(W), .MAX(MAXC), .DIV(1), .SATURATE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    auto_updown_counter #(.WIDTH(W), .MAX(MAXC), .DIV(1), .SATURATE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1));
    auto_updown_counter #(.WIDTH(W), .MAX(MAXC), .DIV(3), .SATURATE(1'b0)) dut2 (
        .clk(clk), .reset(reset), .bus(if2));

    int nvec = 0;
    int nerr = 0;

    // Model: held = direction of a button being held (armed), run = running direction,
    // ph = cycles elapsed since the last step while running.
    int m_cnt[3], m_held[3], m_run[3], m_ph[3], m_wr[3];

    function automatic int div_of(int i); return (i == 2) ? 3 : 1; endfunction
    function automatic int sat_of(int i); return (i == 1) ? 1 : 0; endfunction
    function automatic int m_dir(int i);
        return (m_run[i] == 1) ? 1 : (m_run[i] == -1) ? 2 : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_held[i] = 0; m_run[i] = 0; m_ph[i] = 0; m_wr[i] = 0;
        end
    endtask

    task automatic m_step(input int i, input int d);
        if (d > 0) begin
            if (m_cnt[i] == MAXC) begin m_wr[i] = 1; m_cnt[i] = sat_of(i) ? MAXC : 0; end
            else m_cnt[i] = m_cnt[i] + 1;
        end else begin
            if (m_cnt[i] == 0) begin m_wr[i] = 1; m_cnt[i] = sat_of(i) ? 0 : MAXC; end
            else m_cnt[i] = m_cnt[i] - 1;
        end
    endtask

    task automatic m_release(input int i);
        m_run[i] = m_held[i]; m_held[i] = 0; m_ph[i] = 0;
        m_step(i, m_run[i]);
    endtask

    task automatic m_edge();
        for (int i = 0; i < 3; i++) begin
            m_wr[i] = 0;
            if (i_load) begin
                m_cnt[i] = (int'(i_lv) > MAXC) ? MAXC : int'(i_lv);
                m_held[i] = 0; m_run[i] = 0; m_ph[i] = 0;
            end else if (i_stop) begin
                m_held[i] = 0; m_run[i] = 0; m_ph[i] = 0;
            end else if (i_up) begin
                m_held[i] = 1; m_run[i] = 0; m_ph[i] = 0;
            end else if (i_dn) begin
                if (m_held[i] == 1) m_release(i);
                else begin m_held[i] = -1; m_run[i] = 0; m_ph[i] = 0; end
            end else if (m_held[i] != 0) begin
                m_release(i);
            end else if (m_run[i] != 0) begin
                m_ph[i] = m_ph[i] + 1;
                if (m_ph[i] == div_of(i)) begin m_ph[i] = 0; m_step(i, m_run[i]); end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] c, d, w;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin c = 32'(if0.count); d = 32'(if0.run_dir); w = 32'(if0.wrap); end
                1:       begin c = 32'(if1.count); d = 32'(if1.run_dir); w = 32'(if1.wrap); end
                default: begin c = 32'(if2.count); d = 32'(if2.run_dir); w = 32'(if2.wrap); end
            endcase
            chk($sformatf("%s.d%0d.count", tag, i), c, m_cnt[i]);
            chk($sformatf("%s.d%0d.run_dir", tag, i), d, m_dir(i));
            chk($sformatf("%s.d%0d.wrap", tag, i), w, m_wr[i]);
        end
    endtask

    task automatic set_in(input logic u, input logic d, input logic s, input logic l,
                          input logic [W-1:0] lv);
        i_up = u; i_dn = d; i_stop = s; i_load = l; i_lv = lv;
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cyc(input string tag);
        @(posedge clk);
        m_edge();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        m_reset();
        #1 check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        set_in(0, 0, 0, 0, '0);
        reset = 1'b1;
        m_reset();
        #3 check_all("por");
        @(negedge clk);
        reset = 1'b0;

        // Press and release up: 1 at release, then counting every cycle.
        set_in(1, 0, 0, 0, '0); cyc("up_press");
        set_in(0, 0, 0, 0, '0); cyc("up_release");
        chk("up_release_cnt", 32'(if0.count), 1);
        chk("up_release_dir", 32'(if0.run_dir), 1);
        repeat (3) cyc("up_run");
        chk("up_run_cnt", 32'(if0.count), 4);

        // Load 99 and run up across MAX: wrap vs saturate.
        set_in(0, 0, 0, 1, 7'd99); cyc("ld99");
        set_in(1, 0, 0, 0, '0);    cyc("ld99_press");
        set_in(0, 0, 0, 0, '0);    cyc("ld99_release");
        chk("top_reach", 32'(if0.count), 100);
        cyc("top_step1");
        chk("wrap_cnt", 32'(if0.count), 0);
        chk("wrap_pulse", 32'(if0.wrap), 1);
        chk("sat_cnt", 32'(if1.count), 100);
        chk("sat_pulse", 32'(if1.wrap), 1);
        cyc("top_step2");
        chk("wrap_after", 32'(if0.count), 1);
        chk("wrap_pulse_end", 32'(if0.wrap), 0);
        chk("sat_again", 32'(if1.wrap), 1);

        // DIV=3 down run from 5.
        set_in(0, 0, 0, 1, 7'd5); cyc("ld5");
        set_in(0, 1, 0, 0, '0);   cyc("dn_press");
        set_in(0, 0, 0, 0, '0);   cyc("dn_release");
        chk("div3_rel", 32'(if2.count), 4);
        chk("div3_dir", 32'(if2.run_dir), 2);
        repeat (2) cyc("div3_wait");
        chk("div3_hold", 32'(if2.count), 4);
        cyc("div3_step1");
        chk("div3_step1_cnt", 32'(if2.count), 3);
        repeat (3) cyc("div3_step2");
        chk("div3_step2_cnt", 32'(if2.count), 2);

        // up and down together arm up only; then stop freezes the count.
        set_in(0, 0, 0, 1, 7'd10); cyc("ld10");
        set_in(1, 1, 0, 0, '0);    cyc("both");
        chk("both_cnt", 32'(if0.count), 10);
        chk("both_dir", 32'(if0.run_dir), 0);
        set_in(0, 0, 0, 0, '0);    cyc("both_release");
        cyc("both_run");
        set_in(0, 0, 1, 0, '0);    cyc("stop");
        chk("stop_cnt", 32'(if0.count), 12);
        chk("stop_dir", 32'(if0.run_dir), 0);
        set_in(0, 0, 0, 0, '0);    cyc("stop_hold");
        chk("stop_hold_cnt", 32'(if0.count), 12);

        // Reset mid-run at 37, then an over-range load clamps to MAX.
        set_in(0, 0, 0, 1, 7'd36); cyc("ld36");
        set_in(1, 0, 0, 0, '0);    cyc("r_press");
        set_in(0, 0, 0, 0, '0);    cyc("r_release");
        chk("r_at37", 32'(if0.count), 37);
        pulse_reset("midrun_reset");
        chk("async_rst_cnt", 32'(if0.count), 0);
        chk("async_rst_dir", 32'(if0.run_dir), 0);
        cyc("post_reset");
        set_in(0, 0, 0, 1, 7'd120); cyc("ld120");
        chk("clamp_cnt", 32'(if0.count), 100);

        // Random stimulus.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, r >= 5 && r < 9,
                   r < 5, W'($urandom_range(0, 127)));
            if ($urandom_range(0, 1) == 0 && r >= 9) set_in(0, 0, 0, 0, '0);
            cyc("rnd");
            if ($urandom_range(0, 59) == 0) pulse_reset("rnd_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
